// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the deadlock stall watchdog.
package deadlock_mon_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DEADLOCK} state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction
endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module lsb_prio_enc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/deadlock_stall_watchdog.sv
// Declares deadlock after THRESH consecutive stall cycles; latches the blocked
// channels at declaration and tracks current and longest stall run lengths.
module deadlock_stall_watchdog
  import deadlock_mon_pkg::*;
#(
  parameter int          NUM_AXIS = 2,
  parameter int          NUM_INST = 3,
  parameter int          NUM_BLK  = 1,
  parameter int unsigned THRESH   = 16,
  parameter int          CNT_W    = 16,
  parameter int          IDX_W    = idx_width(NUM_AXIS)
) (
  input  logic                kernel_monitor_clock,
  input  logic                kernel_monitor_reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_BLK-1:0]  inst_block_sigs,
  output logic                block,
  output logic                deadlock,
  output logic                deadlock_pulse,
  output logic [NUM_AXIS-1:0] blocked_mask,
  output logic [IDX_W-1:0]    first_chan,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    max_stall
);
  state_t              state, state_n;
  logic                stall_raw, stall_en, capture;
  logic                dl_n, pulse_n, enc_valid;
  logic [CNT_W-1:0]    cnt_n, cnt_inc;
  logic [NUM_AXIS-1:0] mask_n;
  logic [IDX_W-1:0]    chan_n, enc_idx;

  // A kernel whose instances are all idle has finished, so it is never stalled.
  assign stall_raw = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
  assign stall_en  = stall_raw & enable;
  assign cnt_inc   = CNT_W'(sat_inc(32'(stall_cnt), CNT_W));

  lsb_prio_enc #(.N(NUM_AXIS), .W(IDX_W)) u_enc (
    .req   (axis_block_sigs),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state          <= IDLE;
      block          <= 1'b0;
      deadlock       <= 1'b0;
      deadlock_pulse <= 1'b0;
      blocked_mask   <= '0;
      first_chan     <= '0;
      stall_cnt      <= '0;
      max_stall      <= '0;
    end else begin
      state          <= state_n;
      block          <= stall_en;
      deadlock       <= dl_n;
      deadlock_pulse <= pulse_n;
      blocked_mask   <= mask_n;
      first_chan     <= chan_n;
      stall_cnt      <= cnt_n;
      if (cnt_n > max_stall) max_stall <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    if (clear) state_n = IDLE;
    else begin
      case (state)
        IDLE:
          if (stall_en) begin
            if (THRESH == 1) begin
              state_n = DEADLOCK;
              capture = 1'b1;
            end else state_n = COUNT;
          end
        COUNT:
          if (!stall_en) state_n = IDLE;
          else if (32'(cnt_inc) == THRESH) begin
            state_n = DEADLOCK;
            capture = 1'b1;
          end
        DEADLOCK: state_n = DEADLOCK;
        default:  state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_n   = stall_cnt;
    dl_n    = deadlock;
    pulse_n = 1'b0;
    mask_n  = blocked_mask;
    chan_n  = first_chan;
    if (clear) begin
      cnt_n  = '0;
      dl_n   = 1'b0;
      mask_n = '0;
      chan_n = '0;
    end else begin
      case (state)
        IDLE:     if (stall_en) cnt_n = CNT_W'(1);
        COUNT:    cnt_n = stall_en ? cnt_inc : '0;
        DEADLOCK: if (stall_en) cnt_n = cnt_inc;
        default:  cnt_n = '0;
      endcase
      if (capture) begin
        dl_n    = 1'b1;
        pulse_n = 1'b1;
        mask_n  = axis_block_sigs;
        chan_n  = enc_valid ? enc_idx : '0;
      end
    end
  end
endmodule

// File: tb/tb_deadlock_stall_watchdog.sv
// Three watchdog configurations (THRESH 4/1/2, CNT_W 16/16/3) on shared inputs,
// checked each cycle against a run-length reference model plus directed checks.
module tb_deadlock_stall_watchdog;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear = 1'b0;
  logic [1:0] axis = '0;
  logic [2:0] idle = '0;
  logic [0:0] iblk = '0;

  logic [2:0]      blk_o, dl_o, pl_o, fc_o;
  logic [2:0][1:0] mask_o;
  logic [15:0]     cnt0, max0, cnt1, max1;
  logic [2:0]      cnt2, max2;

  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  deadlock_stall_watchdog #(.NUM_AXIS(2), .NUM_INST(3), .NUM_BLK(1), .THRESH(4), .CNT_W(16)) u_t4 (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .block(blk_o[0]), .deadlock(dl_o[0]), .deadlock_pulse(pl_o[0]), .blocked_mask(mask_o[0]),
    .first_chan(fc_o[0:0]), .stall_cnt(cnt0), .max_stall(max0));

  deadlock_stall_watchdog #(.NUM_AXIS(2), .NUM_INST(3), .NUM_BLK(1), .THRESH(1), .CNT_W(16)) u_t1 (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .block(blk_o[1]), .deadlock(dl_o[1]), .deadlock_pulse(pl_o[1]), .blocked_mask(mask_o[1]),
    .first_chan(fc_o[1:1]), .stall_cnt(cnt1), .max_stall(max1));

  deadlock_stall_watchdog #(.NUM_AXIS(2), .NUM_INST(3), .NUM_BLK(1), .THRESH(2), .CNT_W(3)) u_t2 (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst), .enable(enable), .clear(clear),
    .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .block(blk_o[2]), .deadlock(dl_o[2]), .deadlock_pulse(pl_o[2]), .blocked_mask(mask_o[2]),
    .first_chan(fc_o[2:2]), .stall_cnt(cnt2), .max_stall(max2));

  // Reference model: run length of the current stall and a sticky verdict.
  int         T[3]  = '{4, 1, 2};
  int         CM[3] = '{65535, 65535, 7};
  int         m_cnt[3], m_max[3];
  bit         m_dead[3], m_pulse[3], m_blk[3];
  logic [1:0] m_mask[3];
  logic       m_fc[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_max[i] = 0; m_dead[i] = 0; m_pulse[i] = 0;
      m_blk[i] = 0; m_mask[i] = '0; m_fc[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit stall;
    stall = ((axis != 0) || (iblk != 0)) && (idle != 3'b111);
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_blk[i]   = stall && enable;
      m_pulse[i] = 0;
      if (clear) begin
        m_cnt[i] = 0; m_dead[i] = 0; m_mask[i] = '0; m_fc[i] = 1'b0;
      end else if (stall && enable) begin
        if (m_cnt[i] < CM[i]) m_cnt[i]++;
        if (!m_dead[i] && m_cnt[i] >= T[i]) begin
          m_dead[i] = 1; m_pulse[i] = 1; m_mask[i] = axis;
          m_fc[i] = axis[0] ? 1'b0 : axis[1];
        end
      end else if (!m_dead[i]) m_cnt[i] = 0;
      if (m_cnt[i] > m_max[i]) m_max[i] = m_cnt[i];
    end
  endtask

  function automatic logic [37:0] act_vec(input int i);
    logic [15:0] c, m;
    case (i)
      0:       begin c = cnt0; m = max0; end
      1:       begin c = cnt1; m = max1; end
      default: begin c = {13'b0, cnt2}; m = {13'b0, max2}; end
    endcase
    return {blk_o[i], dl_o[i], pl_o[i], mask_o[i], fc_o[i], c, m};
  endfunction

  function automatic logic [37:0] exp_vec(input int i);
    return {m_blk[i], m_dead[i], m_pulse[i], m_mask[i], m_fc[i], 16'(m_cnt[i]), 16'(m_max[i])};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; axis = 2'b11; idle = 3'b000;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== exp_vec(i)) $display("FAIL reset_model inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
      else passes++;
    end
    checks++;
    if ({blk_o, dl_o, pl_o, mask_o, fc_o, cnt0, max0, cnt1, max1, cnt2, max2} !== '0)
      $display("FAIL reset_zero got dl=%b cnt0=%0d want all zero", dl_o, cnt0);
    else passes++;
    rst = 1'b0; axis = '0;
  endtask

  task automatic test_gap();
    enable = 1'b1; idle = 3'b001; iblk = '0;
    for (int k = 0; k < 8; k++) begin
      axis = (k == 3 || k == 7) ? 2'b00 : 2'b01;
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) $display("FAIL gap inst%0d cyc%0d got %h want %h", i, k, act_vec(i), exp_vec(i));
        else passes++;
      end
    end
    checks++;
    if (dl_o[0] !== 1'b0 || max0 !== 16'd3 || cnt0 !== 16'd0)
      $display("FAIL gap_directed got dl=%b max=%0d cnt=%0d want dl=0 max=3 cnt=0", dl_o[0], max0, cnt0);
    else passes++;
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_all_idle();
    axis = 2'b11; idle = 3'b111;
    repeat (10) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) $display("FAIL all_idle inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
        else passes++;
      end
    end
    checks++;
    if (blk_o !== 3'b000 || dl_o !== 3'b000 || cnt0 !== 16'd0)
      $display("FAIL all_idle_directed got blk=%b dl=%b cnt=%0d want 0 0 0", blk_o, dl_o, cnt0);
    else passes++;
  endtask

  task automatic test_deadlock_basic();
    axis = 2'b10; idle = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) $display("FAIL basic inst%0d cyc%0d got %h want %h", i, k, act_vec(i), exp_vec(i));
        else passes++;
      end
      if (k == 3) begin
        checks++;
        if (dl_o[0] !== 1'b0) $display("FAIL basic_early got dl=%b want 0", dl_o[0]);
        else passes++;
      end
      if (k == 4) begin
        checks++;
        if (dl_o[0] !== 1'b1 || pl_o[0] !== 1'b1 || mask_o[0] !== 2'b10 || fc_o[0] !== 1'b1 || cnt0 !== 16'd4)
          $display("FAIL basic_declare got dl=%b pl=%b mask=%b fc=%b cnt=%0d want 1 1 10 1 4",
                   dl_o[0], pl_o[0], mask_o[0], fc_o[0], cnt0);
        else passes++;
      end
    end
    checks++;
    if (pl_o[0] !== 1'b0 || dl_o[0] !== 1'b1 || cnt0 !== 16'd5)
      $display("FAIL basic_after got pl=%b dl=%b cnt=%0d want 0 1 5", pl_o[0], dl_o[0], cnt0);
    else passes++;
  endtask

  task automatic test_clear();
    clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (dl_o[0] !== 1'b0 || mask_o[0] !== 2'b00 || cnt0 !== 16'd0 || max0 !== 16'd5)
      $display("FAIL clear got dl=%b mask=%b cnt=%0d max=%0d want 0 00 0 5", dl_o[0], mask_o[0], cnt0, max0);
    else passes++;
    step();
    checks++;
    if (cnt0 !== 16'd1 || max0 !== 16'd5) $display("FAIL clear_restart got cnt=%0d max=%0d want 1 5", cnt0, max0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== exp_vec(i)) $display("FAIL clear_model inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
      else passes++;
    end
  endtask

  task automatic test_inst_block_only();
    clear = 1'b1; step(); clear = 1'b0;
    axis = 2'b00; iblk = 1'b1; idle = 3'b001;
    step();
    checks++;
    if (dl_o[1] !== 1'b1 || pl_o[1] !== 1'b1 || fc_o[1] !== 1'b0 || mask_o[1] !== 2'b00)
      $display("FAIL iblk_only got dl=%b pl=%b fc=%b mask=%b want 1 1 0 00", dl_o[1], pl_o[1], fc_o[1], mask_o[1]);
    else passes++;
    iblk = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== exp_vec(i)) $display("FAIL iblk_model inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
      else passes++;
    end
  endtask

  task automatic test_saturation_async_reset();
    clear = 1'b1; step(); clear = 1'b0;
    axis = 2'b01; idle = 3'b010;
    repeat (20) begin
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) $display("FAIL sat inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
        else passes++;
      end
    end
    checks++;
    if (cnt2 !== 3'd7 || max2 !== 3'd7 || dl_o[2] !== 1'b1)
      $display("FAIL sat_directed got cnt=%0d max=%0d dl=%b want 7 7 1", cnt2, max2, dl_o[2]);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({blk_o, dl_o, pl_o, mask_o, fc_o, cnt0, max0, cnt1, max1, cnt2, max2} !== '0)
      $display("FAIL async_reset got dl=%b cnt0=%0d max0=%0d want all zero", dl_o, cnt0, max0);
    else passes++;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic test_random();
    repeat (400) begin
      axis   = 2'($urandom);
      iblk   = 1'($urandom);
      idle   = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 19) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) $display("FAIL random inst%0d got %h want %h", i, act_vec(i), exp_vec(i));
        else passes++;
      end
    end
    rst = 1'b0; clear = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_gap();
    test_all_idle();
    test_deadlock_basic();
    test_clear();
    test_inst_block_only();
    test_saturation_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
